// File: rtl/i2c_config_seq.sv
// Power-up register sequencer: walks a combinational reg/data table and issues one
// I2C register-write per entry to a byte-level master, with NACK retries and pacing.
module i2c_config_seq #(
    parameter logic [6:0] DEV_ADDR    = 7'h39,
    parameter int         NUM_WRITES  = 8,
    parameter int         DELAY_CLKS  = 100_000,
    parameter int         RETRY_LIMIT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] tbl_index,
    input  logic [7:0] tbl_reg,
    input  logic [7:0] tbl_data,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [6:0] cmd_addr,
    output logic [7:0] cmd_reg,
    output logic [7:0] cmd_data,
    input  logic       xfer_done,
    input  logic       xfer_nack,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] err_index
);

    // Handshake: a request is accepted on the clock edge where cmd_valid and
    // cmd_ready are both high; cmd_valid, cmd_reg and cmd_data stay stable until then.

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        DELAY,
        DONE,
        ERROR
    } state_t;

    localparam logic [23:0] DELAY_LAST = 24'(DELAY_CLKS - 1);
    localparam logic [7:0]  LAST_INDEX = 8'(NUM_WRITES);
    localparam logic [3:0]  RETRY_MAX  = 4'(RETRY_LIMIT);

    state_t      state;
    logic [7:0]  index;
    logic [3:0]  retries;
    logic [23:0] delay_cnt;

    assign tbl_index = index;
    assign cmd_addr  = DEV_ADDR;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            index     <= '0;
            retries   <= '0;
            delay_cnt <= '0;
            cmd_valid <= 1'b0;
            cmd_reg   <= '0;
            cmd_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        index     <= '0;
                        retries   <= '0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_index <= '0;
                        busy      <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    cmd_reg   <= tbl_reg;
                    cmd_data  <= tbl_data;
                    cmd_valid <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (xfer_done) begin
                        if (!xfer_nack) begin
                            index   <= index + 8'd1;
                            retries <= '0;
                            state   <= DELAY;
                        end else if (retries < RETRY_MAX) begin
                            // Same index again: the retry re-fetches this entry after the gap.
                            retries <= retries + 4'd1;
                            state   <= DELAY;
                        end else begin
                            err_index <= index;
                            error     <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ERROR;
                        end
                    end
                end
                DELAY: begin
                    if (delay_cnt == DELAY_LAST) begin
                        delay_cnt <= '0;
                        if (index == LAST_INDEX) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            state <= FETCH;
                        end
                    end else begin
                        delay_cnt <= delay_cnt + 24'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_config_seq.sv
// Directed bench for i2c_config_seq: a small I2C master model answers requests and
// a scoreboard queue holds the requests each scenario is expected to produce.
module tb_i2c_config_seq;

    localparam int NUM_WRITES  = 3;
    localparam int DELAY_CLKS  = 4;
    localparam int RETRY_LIMIT = 2;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] tbl_index;
    logic [7:0] tbl_reg;
    logic [7:0] tbl_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_data;
    logic       xfer_done;
    logic       xfer_nack;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] err_index;

    // xfer_done/xfer_nack are split so the master model and the directed
    // sequence can each inject pulses without sharing a driver.
    logic m_done, m_nack, s_done, s_nack;
    assign xfer_done = m_done | s_done;
    assign xfer_nack = m_nack | s_nack;

    i2c_config_seq #(
        .DEV_ADDR   (7'h39),
        .NUM_WRITES (NUM_WRITES),
        .DELAY_CLKS (DELAY_CLKS),
        .RETRY_LIMIT(RETRY_LIMIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .tbl_index(tbl_index),
        .tbl_reg  (tbl_reg),
        .tbl_data (tbl_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_reg  (cmd_reg),
        .cmd_data (cmd_data),
        .xfer_done(xfer_done),
        .xfer_nack(xfer_nack),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_index(err_index)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- configuration table ----------------
    function automatic logic [7:0] ref_reg(input int i);
        case (i)
            0: ref_reg = 8'h41;
            1: ref_reg = 8'h98;
            2: ref_reg = 8'hAF;
            default: ref_reg = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] ref_data(input int i);
        case (i)
            0: ref_data = 8'h10;
            1: ref_data = 8'h03;
            2: ref_data = 8'h16;
            default: ref_data = 8'h00;
        endcase
    endfunction

    always_comb begin
        tbl_reg  = ref_reg(int'(tbl_index));
        tbl_data = ref_data(int'(tbl_index));
    end

    // ---------------- scoreboard ----------------
    logic [22:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_entry(input int i);
        exp_q.push_back({7'h39, ref_reg(i), ref_data(i)});
    endtask

    // ---------------- master model ----------------
    logic        master_hold   = 1'b0;
    int          bp_cycles     = 0;
    logic [7:0]  bp_reg        = 8'h00;
    logic [7:0]  bp_data       = 8'h00;
    logic [7:0]  nack_reg      = 8'h00;
    int          nack_left     = 0;
    logic        spacing_armed = 1'b0;
    int          last_done_cyc = 0;

    initial begin : master
        logic [22:0] exp_w;
        cmd_ready = 1'b0;
        m_done    = 1'b0;
        m_nack    = 1'b0;
        forever begin
            @(negedge clk);
            m_done = 1'b0;
            m_nack = 1'b0;
            if (cmd_valid === 1'b1 && !master_hold && reset === 1'b0) begin
                // xfer_done high in cycle c; next cmd_valid first high in cycle c+6,
                // leaving DELAY_CLKS+1 cycles in between.
                if (spacing_armed)
                    check("done_to_valid_cycles", 32'(cyc - last_done_cyc), 32'(DELAY_CLKS + 2));
                if (bp_cycles != 0 && cmd_reg === bp_reg) begin
                    for (int i = 0; i < bp_cycles; i++) begin
                        check("bp_valid_held", {31'd0, cmd_valid}, 32'd1);
                        check("bp_reg_held", {24'd0, cmd_reg}, {24'd0, bp_reg});
                        check("bp_data_held", {24'd0, cmd_data}, {24'd0, bp_data});
                        @(negedge clk);
                    end
                    bp_cycles = 0;
                end
                check("req_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 23'h0;
                check("req_fields", {9'd0, cmd_addr, cmd_reg, cmd_data}, {9'd0, exp_w});
                cmd_ready = 1'b1;
                @(negedge clk);
                cmd_ready = 1'b0;
                check("single_accept", {31'd0, cmd_valid}, 32'd0);
                repeat (9) @(negedge clk);
                m_done = 1'b1;
                if (nack_left > 0 && exp_w[15:8] == nack_reg) begin
                    m_nack = 1'b1;
                    nack_left--;
                end
                last_done_cyc = cyc;
                spacing_armed = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic first);
        @(negedge clk);
        if (first) spacing_armed = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_valid(input logic level, input string tag);
        int n = 0;
        while (cmd_valid !== level && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, cmd_valid}, {31'd0, level});
    endtask

    task automatic wait_index(input logic [7:0] idx, input string tag);
        int n = 0;
        while (tbl_index !== idx && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, {24'd0, tbl_index}, {24'd0, idx});
    endtask

    task automatic check_reset_outputs();
        check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_err_index", {24'd0, err_index}, 32'd0);
        check("rst_tbl_index", {24'd0, tbl_index}, 32'd0);
        check("rst_cmd_reg", {24'd0, cmd_reg}, 32'd0);
        check("rst_cmd_data", {24'd0, cmd_data}, 32'd0);
        check("rst_cmd_addr", {25'd0, cmd_addr}, 32'h39);
    endtask

    task automatic check_end(input logic exp_done, input logic exp_err, input string tag);
        check({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        check({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        reset  = 1'b1;
        start  = 1'b0;
        s_done = 1'b0;
        s_nack = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        @(negedge clk);

        // Spurious xfer_done while idle changes nothing.
        s_done = 1'b1;
        @(negedge clk);
        s_done = 1'b0;
        @(negedge clk);
        check("idle_spur_busy", {31'd0, busy}, 32'd0);
        check("idle_spur_index", {24'd0, tbl_index}, 32'd0);
        check("idle_spur_valid", {31'd0, cmd_valid}, 32'd0);

        // Plain three-entry sequence with start latency.
        for (int i = 0; i < 3; i++) push_entry(i);
        do_start(1'b1);
        check("start_lat_cyc1_valid", {31'd0, cmd_valid}, 32'd0);
        check("start_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("start_lat_cyc2_valid", {31'd0, cmd_valid}, 32'd1);
        wait_idle("basic_timeout");
        check_end(1'b1, 1'b0, "basic");
        check("basic_final_index", {24'd0, tbl_index}, 32'd3);

        // Backpressure on entry 1 for seven cycles.
        bp_reg    = 8'h98;
        bp_data   = 8'h03;
        bp_cycles = 7;
        for (int i = 0; i < 3; i++) push_entry(i);
        do_start(1'b1);
        check("restart_clears_done", {31'd0, done}, 32'd0);
        wait_idle("bp_timeout");
        check_end(1'b1, 1'b0, "bp");
        check("bp_consumed", 32'(bp_cycles), 32'd0);

        // Entry 1 NACKs once, then ACKs.
        nack_reg  = 8'h98;
        nack_left = 1;
        push_entry(0); push_entry(1); push_entry(1); push_entry(2);
        do_start(1'b1);
        wait_idle("nack1_timeout");
        check_end(1'b1, 1'b0, "nack1");

        // Entry 2 NACKs every time: 1 + RETRY_LIMIT attempts, then error.
        nack_reg  = 8'hAF;
        nack_left = 100;
        push_entry(0); push_entry(1);
        for (int i = 0; i <= RETRY_LIMIT; i++) push_entry(2);
        do_start(1'b1);
        wait_idle("nackall_timeout");
        check_end(1'b0, 1'b1, "nackall");
        check("nackall_err_index", {24'd0, err_index}, 32'd2);
        repeat (20) @(negedge clk);
        check("nackall_quiet_valid", {31'd0, cmd_valid}, 32'd0);
        check("nackall_error_held", {31'd0, error}, 32'd1);
        nack_left = 0;

        // start during WAIT and xfer_done during DELAY are ignored.
        for (int i = 0; i < 3; i++) push_entry(i);
        do_start(1'b1);
        check("err_cleared_by_start", {31'd0, error}, 32'd0);
        wait_valid(1'b1, "ign_first_valid");
        wait_valid(1'b0, "ign_accepted");
        do_start(1'b0);
        @(negedge clk);
        check("wait_start_index", {24'd0, tbl_index}, 32'd0);
        check("wait_start_valid", {31'd0, cmd_valid}, 32'd0);
        check("wait_start_busy", {31'd0, busy}, 32'd1);
        wait_index(8'd1, "ign_reach_delay");
        s_done = 1'b1;
        @(negedge clk);
        s_done = 1'b0;
        check("delay_spur_index", {24'd0, tbl_index}, 32'd1);
        check("delay_spur_valid", {31'd0, cmd_valid}, 32'd0);
        wait_idle("ign_timeout");
        check_end(1'b1, 1'b0, "ign");

        // Reset while a request is pending, then a full clean run.
        master_hold = 1'b1;
        do_start(1'b1);
        wait_valid(1'b1, "rst_pending_valid");
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        master_hold = 1'b0;
        for (int i = 0; i < 3; i++) push_entry(i);
        do_start(1'b1);
        wait_idle("post_rst_timeout");
        check_end(1'b1, 1'b0, "post_rst");

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
